jtag_uart_ctrl: RTL and testbench

JTAG_UART_CTRL -- requirements
Module: jtag_uart_ctrl

---
 rtl/jtag_uart_ctrl.sv | 130 +++++++++++++
 tb/tb_jtag_uart_ctrl.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_uart_ctrl.sv
// jtag_uart_ctrl: byte-stream bridge to an Avalon JTAG UART slave with a TX byte FIFO and polled RX.
// Define JTAG_UART_CTRL_RX_EN to build the RX polling path; without it only TX is serviced.
module jtag_uart_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int POLL_CYCLES = 16
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        avm_chipselect,
    output logic        avm_address,
    output logic        avm_read_n,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    input  logic        uart_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] POLL_RELOAD = 16'(POLL_CYCLES - 1);
    typedef enum logic [2:0] {IDLE, RD_CTRL, WR_DATA, RD_DATA, RX_HOLD} state_t;
    state_t state, state_n;
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic [15:0] wspace, poll;
    logic rr_tx;
    logic done, empty, push, pop, tx_elig, rx_elig, grant_tx;
    logic unused_in;
`ifdef JTAG_UART_CTRL_RX_EN
    logic ravail_nz;
`endif
    assign unused_in = ^{uart_irq, rx_ready, avm_readdata[15:0]};
    assign done     = !avm_waitrequest;
    assign empty    = count == '0;
    assign tx_ready = count != FIFO_DEPTH[AW:0];
    assign push     = tx_valid && tx_ready;
    assign pop      = state == WR_DATA && done && !empty;
    // with no write space known, control reads are rate-limited by the poll timer
    assign tx_elig  = !empty && (wspace != '0 || poll == '0);
`ifdef JTAG_UART_CTRL_RX_EN
    assign rx_elig  = poll == '0 || uart_irq;
`else
    assign rx_elig  = 1'b0;
`endif
    assign grant_tx = tx_elig && (!rx_elig || !rr_tx);

    always_ff @(posedge clk_clk) begin
        if (reset_reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:             state_n = grant_tx ? (wspace == '0 ? RD_CTRL : WR_DATA) : rx_elig ? RD_DATA : IDLE;
            RD_CTRL, WR_DATA: state_n = done ? IDLE : state;
            RD_DATA:          state_n = !done ? RD_DATA : avm_readdata[15] ? RX_HOLD : IDLE;
            RX_HOLD:          state_n = rx_ready ? IDLE : RX_HOLD;
            default:          state_n = IDLE;
        endcase
    end

    always_comb begin
        avm_chipselect = state == RD_CTRL || state == WR_DATA || state == RD_DATA;
        avm_address    = state == RD_CTRL;
        avm_read_n     = !(state == RD_CTRL || state == RD_DATA);
        avm_write_n    = state != WR_DATA;
        avm_writedata  = state == WR_DATA ? {24'h0, mem[rd_ptr]} : 32'h0;
    end

    always_ff @(posedge clk_clk) begin
        if (push)
            mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            wspace   <= '0;
            poll     <= '0;
            rr_tx    <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
`ifdef JTAG_UART_CTRL_RX_EN
            ravail_nz <= 1'b0;
`endif
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (state == IDLE && state_n != IDLE)
                rr_tx <= grant_tx;
            if (state == RD_CTRL && done)
                wspace <= avm_readdata[31:16];
            else if (pop && wspace != '0)
                wspace <= wspace - 1'b1;
            if (state == RD_CTRL && done && avm_readdata[31:16] == '0)
                poll <= POLL_RELOAD;
            else if (state != RD_DATA && state != RX_HOLD && poll != '0)
                poll <= poll - 1'b1;
`ifdef JTAG_UART_CTRL_RX_EN
            if (state == RD_DATA && done) begin
                if (avm_readdata[15]) begin
                    rx_valid  <= 1'b1;
                    rx_data   <= avm_readdata[7:0];
                    ravail_nz <= avm_readdata[31:16] != '0;
                end else
                    poll <= POLL_RELOAD;
            end
            // more bytes waiting in the slave means poll again immediately
            if (state == RX_HOLD && rx_ready) begin
                rx_valid <= 1'b0;
                poll     <= ravail_nz ? 16'h0 : POLL_RELOAD;
            end
`endif
        end
    end
endmodule

// File: tb/tb_jtag_uart_ctrl.sv
// tb_jtag_uart_ctrl: directed and random checks of jtag_uart_ctrl against a queue-based slave/FIFO model.
module tb_jtag_uart_ctrl;
    localparam int FIFO_DEPTH  = 4;
    localparam int POLL_CYCLES = 16;
    localparam logic [35:0] IDLE_VEC = {1'b0, 1'b0, 1'b1, 1'b1, 32'h0};

    logic        clk_clk, reset_reset, tx_valid, tx_ready, rx_valid, rx_ready;
    logic [7:0]  tx_data, rx_data;
    logic        avm_chipselect, avm_address, avm_read_n, avm_write_n, avm_waitrequest, uart_irq;
    logic [31:0] avm_writedata, avm_readdata, ctrl_word, data_word;
    logic        stall;
    logic [35:0] avm_vec, prev_vec;
    logic        prev_stall, mpush, mpop;

    int checks = 0, errors = 0;
    int mcount = 0, credit = 0, cyc = 0, ctrl_cyc = 0, wr_cycles = 0, data_reads = 0;
    bit ctrl0 = 0;
    int n0, w0, j, d0, code;
    logic [7:0] exp_q[$];
    int tx_log[$];
    int all_log[$];

    jtag_uart_ctrl #(.FIFO_DEPTH(FIFO_DEPTH), .POLL_CYCLES(POLL_CYCLES)) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .avm_chipselect(avm_chipselect), .avm_address(avm_address),
        .avm_read_n(avm_read_n), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .uart_irq(uart_irq)
    );

    assign avm_readdata    = avm_address ? ctrl_word : data_word;
    assign avm_waitrequest = stall;
    assign avm_vec = {avm_chipselect, avm_address, avm_read_n, avm_write_n, avm_writedata};

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        tx_valid = 1'b1;
        tx_data  = b;
        step(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int n, input int bound);
        for (int i = 0; i < bound && tx_log.size() < n; i++)
            step(1);
        check("wait_tx", tx_log.size() >= n, 1);
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && mcount != 0; i++)
            step(1);
        check("drain", mcount, 0);
    endtask

    // Reference model: bytes leave in push order, writes only with credit, control reads only without credit
    always @(negedge clk_clk) begin
        if (reset_reset) begin
            exp_q.delete();
            mcount = 0;
            credit = 0;
            ctrl0 = 0;
            prev_stall = 0;
        end else begin
            cyc++;
            mpop = 0;
            check("tx_ready", tx_ready, mcount < FIFO_DEPTH);
            if (!avm_chipselect)
                check("idle_outputs", avm_vec, IDLE_VEC);
            if (prev_stall)
                check("stall_hold", avm_vec, prev_vec);
`ifndef JTAG_UART_CTRL_RX_EN
            check("rx_idle", {rx_valid, rx_data}, 0);
            check("no_data_read", avm_chipselect && !avm_read_n && !avm_address, 0);
`endif
            mpush = tx_valid && mcount < FIFO_DEPTH;
            if (avm_chipselect && !avm_write_n)
                wr_cycles++;
            if (avm_chipselect && !avm_waitrequest) begin
                if (!avm_write_n) begin
                    check("wr_credit", credit > 0, 1);
                    check("wr_nonempty", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        check("wr_data", avm_writedata, {24'h0, exp_q[0]});
                        void'(exp_q.pop_front());
                        mpop = 1;
                    end
                    if (credit > 0)
                        credit--;
                    code = 512 + int'(avm_writedata[7:0]);
                end else if (avm_address) begin
                    check("ctrl_credit", credit == 0, 1);
                    if (ctrl0)
                        check("ctrl_spacing", cyc - ctrl_cyc >= POLL_CYCLES, 1);
                    credit = int'(ctrl_word[31:16]);
                    ctrl0 = credit == 0;
                    ctrl_cyc = cyc;
                    code = 256;
                end else begin
                    data_reads++;
                    code = 768;
                end
                all_log.push_back(code);
                if (code != 768)
                    tx_log.push_back(code);
            end
            if (mpush)
                exp_q.push_back(tx_data);
            mcount = mcount + int'(mpush) - int'(mpop);
            prev_vec = avm_vec;
            prev_stall = avm_chipselect && avm_waitrequest;
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_reset = 1; tx_valid = 0; tx_data = 0; rx_ready = 0; uart_irq = 0; stall = 0;
        ctrl_word = 32'h0; data_word = 32'h0;
`ifdef JTAG_UART_CTRL_RX_EN
        data_word = 32'h0002_8055;
`endif
        step(3);
        reset_reset = 0;
        check("rst_tx_ready", tx_ready, 1);
        check("rst_avm", avm_vec, IDLE_VEC);
        check("rst_rx", {rx_valid, rx_data}, 0);

`ifdef JTAG_UART_CTRL_RX_EN
        for (int i = 0; i < 20 && !rx_valid; i++)
            step(1);
        check("rx_valid_set", rx_valid, 1);
        check("rx_data", rx_data, 8'h55);
        d0 = data_reads;
        step(5);
        check("rx_hold", rx_valid, 1);
        check("hold_no_poll", data_reads, d0);
        data_word = 32'h0;
        rx_ready = 1;
        step(1);
        rx_ready = 0;
        check("rx_clear", rx_valid, 0);
        step(1);
        check("repoll_strobe", {avm_chipselect, avm_address, avm_read_n}, 3'b100);

        uart_irq = 1;
        ctrl_word = 32'h0040_0000;
        n0 = all_log.size();
        tx_valid = 1;
        for (int i = 0; i < 3; i++) begin
            tx_data = 8'hA0 + 8'(i);
            step(1);
        end
        tx_valid = 0;
        wait_drain(200);
        step(4);
        j = n0;
        while (j < all_log.size() && all_log[j] == 768)
            j++;
        check("rr_log_len", all_log.size() >= j + 7, 1);
        for (int k = 0; k < 7; k++)
            check("rr_alternate", all_log[j + k] != 768, k % 2 == 0);

        uart_irq = 0;
        stall = 1;
        for (int i = 0; i < 40 && !(avm_chipselect && !avm_read_n && !avm_address); i++)
            step(1);
        check("rd_data_seen", avm_chipselect && !avm_read_n && !avm_address, 1);
        reset_reset = 1;
        step(1);
        reset_reset = 0;
        stall = 0;
        check("rst_mid_rd", avm_vec, IDLE_VEC);
        check("rst_mid_rx", rx_valid, 0);
`else
        ctrl_word = 32'h0040_0000;
        push_byte(8'h41);
        wait_tx(2, 20);
        check("first_ctrl", tx_log[0], 256);
        check("first_write", tx_log[1], 512 + 8'h41);
        for (int i = 0; i < 3; i++)
            push_byte(8'h42 + 8'(i));
        wait_tx(5, 40);
        for (int i = 2; i < 5; i++)
            check("no_reread", tx_log[i], 512 + 8'h40 + i);

        w0 = wr_cycles;
        n0 = tx_log.size();
        stall = 1;
        push_byte(8'h5A);
        for (int i = 0; i < 20 && avm_write_n; i++)
            step(1);
        check("wr_strobe_seen", avm_write_n, 0);
        step(3);
        stall = 0;
        step(2);
        check("stall_wr_cycles", wr_cycles - w0, 4);
        check("stall_one_pop", tx_log.size() - n0, 1);
        check("stall_byte", tx_log[tx_log.size() - 1], 512 + 8'h5A);

        stall = 1;
        tx_valid = 1;
        for (int i = 0; i < 6; i++) begin
            tx_data = 8'($urandom);
            step(1);
        end
        check("full_tx_ready", tx_ready, 0);
        tx_data = 8'hEE;
        stall = 0;
        step(1);
        stall = 1;
        tx_data = 8'h3C;
        check("pushpop_full", tx_ready, 1);
        step(1);
        tx_valid = 0;
        check("refill_full", tx_ready, 0);
        stall = 0;
        wait_drain(60);

        stall = 1;
        push_byte(8'h77);
        for (int i = 0; i < 20 && avm_write_n; i++)
            step(1);
        check("wr_before_rst", avm_write_n, 0);
        reset_reset = 1;
        step(1);
        reset_reset = 0;
        stall = 0;
        check("rst_mid_wr", avm_vec, IDLE_VEC);
        check("rst_mid_tx_ready", tx_ready, 1);
        ctrl_word = 32'h0002_0000;
        n0 = tx_log.size();
        push_byte(8'h12);
        wait_tx(n0 + 2, 20);
        check("post_rst_ctrl", tx_log[n0], 256);
        check("post_rst_write", tx_log[n0 + 1], 512 + 8'h12);

        uart_irq = 1;
        step(40);
        uart_irq = 0;
        check("irq_no_reads", data_reads, 0);
        check("irq_rx_valid", rx_valid, 0);
`endif

        data_word = 32'h0;
        for (int i = 0; i < 400; i++) begin
            tx_valid  = 1'($urandom_range(0, 1));
            tx_data   = 8'($urandom);
            stall     = $urandom_range(0, 3) == 0;
            ctrl_word = {16'($urandom_range(0, 3)), 16'($urandom)};
            uart_irq  = $urandom_range(0, 7) == 0;
            rx_ready  = 1'($urandom_range(0, 1));
            step(1);
        end
        tx_valid = 0;
        stall = 0;
        uart_irq = 0;
        ctrl_word = 32'h0010_0000;
        wait_drain(300);
        check("drain_queue", exp_q.size(), 0);
`ifndef JTAG_UART_CTRL_RX_EN
        check("final_no_reads", data_reads, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
